write_back_stage: RTL and testbench

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

---
 rtl/write_back_stage.sv | 180 ++++++++++++++++++
 tb/tb_write_back_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// Write-back stage: retires ALU results and loads into the register file.
// Loads wait in WAIT_MEM for mem_rvalid. A load is abandoned after
// TIMEOUT_CYCLES cycles without data.
// Optional feature: define WB_RETIRE_COUNT_EN to add the retire_count output,
// which counts completed instructions.
module write_back_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reg_write_in,
    input  logic        mem_to_reg,
    input  logic [2:0]  funct3,
    input  logic [4:0]  write_back_id_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        reg_write,
    output logic [4:0]  write_id,
    output logic [31:0] write_data,
    output logic        stall,
    output logic        load_timeout
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [31:0] retire_count
`endif
);

    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    localparam logic [4:0] TIMEOUT_LIMIT = 5'(TIMEOUT_CYCLES);

    state_t      state_reg, state_next;
    logic [2:0]  l_funct3_reg;
    logic [1:0]  l_offset_reg;
    logic [4:0]  l_id_reg;
    logic        l_wr_reg;
    logic [4:0]  cnt_reg;
    logic        reg_write_reg;
    logic [4:0]  write_id_reg;
    logic [31:0] write_data_reg;
    logic        load_timeout_reg;

    logic        accept;
    logic        load_done;
    logic        timeout_hit;
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;
    logic        wr_fire;
    logic [4:0]  wr_id;
    logic [31:0] wr_data;
    logic        retire_fire;

    assign accept      = in_valid && in_ready;
    assign load_done   = (state_reg == WAIT_MEM) && mem_rvalid;
    // The cycle whose increment reaches the limit times out, unless data arrives in it.
    assign timeout_hit = (state_reg == WAIT_MEM) && !mem_rvalid &&
                         ((cnt_reg + 5'd1) == TIMEOUT_LIMIT);

    // Split the returned word into its byte lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (accept && mem_to_reg) state_next = WAIT_MEM;
            WAIT_MEM: if (mem_rvalid || timeout_hit) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // FSM outputs: new instructions are accepted only while idle.
    always_comb begin
        in_ready = (state_reg == IDLE);
    end

    assign stall = !in_ready;

    // Extend the selected byte or halfword according to the latched funct3.
    always_comb begin
        byte_sel = lane[l_offset_reg];
        half_sel = l_offset_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (l_funct3_reg)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_value = {24'd0, byte_sel};
            3'b101:  load_value = {16'd0, half_sel};
            default: load_value = mem_rdata;
        endcase
    end

    // Choose what retires this cycle. Writes to x0 still retire but never write.
    always_comb begin
        wr_fire     = 1'b0;
        wr_id       = write_back_id_in;
        wr_data     = alu_result;
        retire_fire = 1'b0;
        if (state_reg == IDLE && accept && !mem_to_reg) begin
            wr_fire     = reg_write_in && (write_back_id_in != 5'd0);
            retire_fire = 1'b1;
        end else if (load_done) begin
            wr_fire     = l_wr_reg && (l_id_reg != 5'd0);
            wr_id       = l_id_reg;
            wr_data     = load_value;
            retire_fire = 1'b1;
        end
    end

    // Latch load context on accept and run the wait-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_funct3_reg <= 3'd0;
            l_offset_reg <= 2'd0;
            l_id_reg     <= 5'd0;
            l_wr_reg     <= 1'b0;
            cnt_reg      <= 5'd0;
        end else if (accept && mem_to_reg) begin
            l_funct3_reg <= funct3;
            l_offset_reg <= alu_result[1:0];
            l_id_reg     <= write_back_id_in;
            l_wr_reg     <= reg_write_in;
            cnt_reg      <= 5'd0;
        end else if (state_reg == WAIT_MEM && !mem_rvalid) begin
            cnt_reg <= cnt_reg + 5'd1;
        end
    end

    // Register-file write port: one-cycle enable pulse, address/data hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_reg    <= 1'b0;
            write_id_reg     <= 5'd0;
            write_data_reg   <= 32'd0;
            load_timeout_reg <= 1'b0;
        end else begin
            reg_write_reg    <= wr_fire;
            load_timeout_reg <= timeout_hit;
            if (wr_fire) begin
                write_id_reg   <= wr_id;
                write_data_reg <= wr_data;
            end
        end
    end

    assign reg_write    = reg_write_reg;
    assign write_id     = write_id_reg;
    assign write_data   = write_data_reg;
    assign load_timeout = load_timeout_reg;

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_count_reg;

    // Count every completed instruction; abandoned loads are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             retire_count_reg <= 32'd0;
        else if (retire_fire) retire_count_reg <= retire_count_reg + 32'd1;
    end

    assign retire_count = retire_count_reg;
`else
    logic unused_retire;
    assign unused_retire = retire_fire;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Directed testbench for write_back_stage.
module tb_write_back_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reg_write_in = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [4:0]  write_back_id_in = 5'd0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic        reg_write;
    logic [4:0]  write_id;
    logic [31:0] write_data;
    logic        stall;
    logic        load_timeout;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_retire = 0;

    write_back_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .reg_write_in     (reg_write_in),
        .mem_to_reg       (mem_to_reg),
        .funct3           (funct3),
        .write_back_id_in (write_back_id_in),
        .alu_result       (alu_result),
        .mem_rdata        (mem_rdata),
        .mem_rvalid       (mem_rvalid),
        .reg_write        (reg_write),
        .write_id         (write_id),
        .write_data       (write_data),
        .stall            (stall),
        .load_timeout     (load_timeout)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .retire_count     (retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_retire(input string tag);
`ifdef WB_RETIRE_COUNT_EN
        check(tag, retire_count, 32'(exp_retire));
`endif
    endtask

    // One non-load instruction; checks the registered write one cycle later.
    task automatic do_alu(input logic wr, input logic [4:0] id, input logic [31:0] val, input logic exp_we);
        in_valid = 1'b1; mem_to_reg = 1'b0; reg_write_in = wr;
        write_back_id_in = id; alu_result = val;
        tick();
        in_valid = 1'b0;
        exp_retire++;
        check("alu_we", {31'd0, reg_write}, {31'd0, exp_we});
        if (exp_we) begin
            check("alu_id", {27'd0, write_id}, {27'd0, id});
            check("alu_data", write_data, val);
        end
        check_retire("alu_retire");
        $display("txn alu id=%0d data=%h we=%0b", id, val, reg_write);
    endtask

    // One load with data arriving in the delay-th WAIT_MEM cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] rdata, input int delay, input logic [31:0] exp);
        in_valid = 1'b1; mem_to_reg = 1'b1; reg_write_in = 1'b1;
        funct3 = f3; write_back_id_in = 5'd10; alu_result = 32'h0000_1000 | {30'd0, off};
        tick();
        in_valid = 1'b0; mem_to_reg = 1'b0;
        for (int k = 1; k <= delay; k++) begin
            check({tag, "_stall"}, {31'd0, stall}, 32'd1);
            check({tag, "_nowe"}, {31'd0, reg_write}, 32'd0);
            if (k == delay) begin
                mem_rvalid = 1'b1;
                mem_rdata = rdata;
            end
            tick();
        end
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        exp_retire++;
        check({tag, "_we"}, {31'd0, reg_write}, 32'd1);
        check({tag, "_id"}, {27'd0, write_id}, 32'd10);
        check({tag, "_data"}, write_data, exp);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_noto"}, {31'd0, load_timeout}, 32'd0);
        check_retire({tag, "_retire"});
        $display("txn %s f3=%0d off=%0d rdata=%h data=%h", tag, f3, off, rdata, write_data);
        tick();
        check({tag, "_pulse"}, {31'd0, reg_write}, 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        tick(); tick();
        check("rst_we", {31'd0, reg_write}, 32'd0);
        check("rst_id", {27'd0, write_id}, 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_to", {31'd0, load_timeout}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check_retire("rst_retire");
        rst = 1'b1;
        tick();

        // ALU write and pulse/hold behaviour
        do_alu(1'b1, 5'd5, 32'h0000_1234, 1'b1);
        tick();
        check("alu_pulse", {31'd0, reg_write}, 32'd0);
        check("alu_hold", write_data, 32'h0000_1234);

        // Back-to-back non-loads at one per cycle
        in_valid = 1'b1; mem_to_reg = 1'b0; reg_write_in = 1'b1;
        write_back_id_in = 5'd7; alu_result = 32'hAAAA_0001;
        tick();
        check("b2b1_we", {31'd0, reg_write}, 32'd1);
        check("b2b1_data", write_data, 32'hAAAA_0001);
        write_back_id_in = 5'd8; alu_result = 32'hBBBB_0002;
        tick();
        in_valid = 1'b0;
        exp_retire += 2;
        check("b2b2_we", {31'd0, reg_write}, 32'd1);
        check("b2b2_id", {27'd0, write_id}, 32'd8);
        check("b2b2_data", write_data, 32'hBBBB_0002);
        check_retire("b2b_retire");
        $display("txn b2b ids 7,8");

        // Write to x0 is suppressed but retires; reg_write_in=0 likewise
        do_alu(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
        do_alu(1'b0, 5'd3, 32'h0BAD_F00D, 1'b0);

        // Load extension cases
        do_load("lb3",  3'b000, 2'd3, 32'h80FF_0000, 3, 32'hFFFF_FF80);
        do_load("lbu3", 3'b100, 2'd3, 32'h80FF_0000, 3, 32'h0000_0080);
        do_load("lh2",  3'b001, 2'd2, 32'h8001_7FFF, 1, 32'hFFFF_8001);
        do_load("lhu2", 3'b101, 2'd2, 32'h8001_7FFF, 2, 32'h0000_8001);
        do_load("lb0",  3'b000, 2'd0, 32'h1234_567F, 1, 32'h0000_007F);
        do_load("lb1",  3'b000, 2'd1, 32'h1234_A67F, 1, 32'hFFFF_FFA6);
        do_load("lh0",  3'b001, 2'd0, 32'h1234_8000, 1, 32'hFFFF_8000);
        do_load("lw1",  3'b010, 2'd1, 32'h1234_5678, 1, 32'h1234_5678);
        do_load("f3_3", 3'b011, 2'd2, 32'hCAFE_BABE, 1, 32'hCAFE_BABE);
        // Data on the last allowed cycle wins over the timeout
        do_load("edge16", 3'b010, 2'd0, 32'h0000_BEEF, 16, 32'h0000_BEEF);

        // Load timeout
        in_valid = 1'b1; mem_to_reg = 1'b1; reg_write_in = 1'b1;
        funct3 = 3'b010; write_back_id_in = 5'd11; alu_result = 32'h2000;
        tick();
        in_valid = 1'b0; mem_to_reg = 1'b0;
        n = 0;
        while (stall && n < 40) begin
            if (load_timeout) check("to_early", {31'd0, load_timeout}, 32'd0);
            n++;
            tick();
        end
        check("to_cycles", 32'(n), 32'd16);
        check("to_pulse", {31'd0, load_timeout}, 32'd1);
        check("to_nowe", {31'd0, reg_write}, 32'd0);
        check("to_ready", {31'd0, in_ready}, 32'd1);
        check_retire("to_retire");
        $display("txn timeout after %0d cycles", n);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        check("to_once", {31'd0, load_timeout}, 32'd0);
        check("late_nowe", {31'd0, reg_write}, 32'd0);
        check("late_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("late_nowe2", {31'd0, reg_write}, 32'd0);
        check_retire("late_retire");

        // Reset in the middle of a load
        in_valid = 1'b1; mem_to_reg = 1'b1; reg_write_in = 1'b1;
        funct3 = 3'b010; write_back_id_in = 5'd12; alu_result = 32'h3000;
        tick();
        in_valid = 1'b0; mem_to_reg = 1'b0;
        check("mid_stall", {31'd0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        exp_retire = 0;
        check("mid_we", {31'd0, reg_write}, 32'd0);
        check("mid_id", {27'd0, write_id}, 32'd0);
        check("mid_data", write_data, 32'd0);
        check("mid_ready", {31'd0, in_ready}, 32'd1);
        check_retire("mid_retire");
        tick(); tick();
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        check("mid_late_nowe", {31'd0, reg_write}, 32'd0);
        check("mid_late_data", write_data, 32'd0);
        $display("txn reset mid-load");
        do_alu(1'b1, 5'd9, 32'h0000_0055, 1'b1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
